// File: rtl/addsub_pkg.sv
// Shared constants and helpers for the pipelined add/subtract unit.
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int unsigned SAT_W = 64;

  // Saturation value for a beat, right-aligned in SAT_W bits; the caller truncates to its width.
  function automatic logic [SAT_W-1:0] sat_value(input logic sgn, input logic op,
                                                 input logic a_msb, input int unsigned width);
    logic [SAT_W-1:0] ones;
    ones = {SAT_W{1'b1}} >> (SAT_W - width);
    if (sgn) begin
      sat_value = a_msb ? (ones ^ (ones >> 1)) : (ones >> 1);
    end else begin
      sat_value = (op == OP_SUB) ? '0 : ones;
    end
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// Combinational SW-bit adder slice with carry-in and carry-out.
module addsub_slice #(
  parameter int unsigned SW = 8
) (
  input  logic [SW-1:0] i_a,
  input  logic [SW-1:0] i_b,
  input  logic          i_cin,
  output logic [SW-1:0] o_sum,
  output logic          o_cout
);

  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{SW{1'b0}}, i_cin};

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined two's-complement add/subtract with per-beat op, overflow rules,
// optional saturation and a sticky overflow flag; one carry slice per stage.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_op,
  input  logic             in_signed,
  input  logic             in_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             ovf_sticky,
  input  logic             sticky_clr
);

  localparam int unsigned SW   = WIDTH / STAGES;
  localparam int unsigned LAST = STAGES - 1;
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SW{1'b1}});

  logic w_en;
  logic w_acc;

  // Stage-k operands as seen by slice k (inputs for k=0, else stage k-1 registers)
  logic             w_s_vld  [STAGES];
  logic             w_s_op   [STAGES];
  logic             w_s_sgn  [STAGES];
  logic             w_s_sat  [STAGES];
  logic             w_s_amsb [STAGES];
  logic             w_s_bmsb [STAGES];
  logic             w_s_cin  [STAGES];
  logic [WIDTH-1:0] w_s_a    [STAGES];
  logic [WIDTH-1:0] w_s_b    [STAGES];
  logic [WIDTH-1:0] w_s_sum  [STAGES];
  logic [WIDTH-1:0] w_o_sum  [STAGES];
  logic [SW-1:0]    w_sl_sum [STAGES];
  logic             w_sl_cout[STAGES];

  logic             r_vld  [STAGES];
  logic             r_op   [STAGES];
  logic             r_sgn  [STAGES];
  logic             r_sat  [STAGES];
  logic             r_amsb [STAGES];
  logic             r_bmsb [STAGES];
  logic             r_c    [STAGES];
  logic [WIDTH-1:0] r_a    [STAGES];
  logic [WIDTH-1:0] r_b    [STAGES];
  logic [WIDTH-1:0] r_sum  [STAGES];

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_result;
  logic             r_out_carry;
  logic             r_out_ovf;
  logic             r_ovf_sticky;

  assign w_en  = !(r_out_valid && !out_ready);
  assign w_acc = in_valid && w_en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LO = k * SW;
    if (k == 0) begin : g_src_in
      assign w_s_vld[k]  = w_acc;
      assign w_s_op[k]   = in_op;
      assign w_s_sgn[k]  = in_signed;
      assign w_s_sat[k]  = in_sat;
      assign w_s_amsb[k] = in_a[WIDTH-1];
      assign w_s_bmsb[k] = in_b[WIDTH-1];
      assign w_s_cin[k]  = in_op;
      assign w_s_a[k]    = in_a;
      assign w_s_b[k]    = (in_op == OP_SUB) ? ~in_b : in_b;
      assign w_s_sum[k]  = '0;
    end else begin : g_src_reg
      assign w_s_vld[k]  = r_vld[k-1];
      assign w_s_op[k]   = r_op[k-1];
      assign w_s_sgn[k]  = r_sgn[k-1];
      assign w_s_sat[k]  = r_sat[k-1];
      assign w_s_amsb[k] = r_amsb[k-1];
      assign w_s_bmsb[k] = r_bmsb[k-1];
      assign w_s_cin[k]  = r_c[k-1];
      assign w_s_a[k]    = r_a[k-1];
      assign w_s_b[k]    = r_b[k-1];
      assign w_s_sum[k]  = r_sum[k-1];
    end

    addsub_slice #(.SW(SW)) u_slice (
      .i_a   (w_s_a[k][LO +: SW]),
      .i_b   (w_s_b[k][LO +: SW]),
      .i_cin (w_s_cin[k]),
      .o_sum (w_sl_sum[k]),
      .o_cout(w_sl_cout[k])
    );

    assign w_o_sum[k] = (w_s_sum[k] & ~(SLICE_MASK << LO)) | (WIDTH'(w_sl_sum[k]) << LO);
  end

  // A single-stage pipe has no intermediate registers to feed
  if (STAGES == 1) begin : g_no_mid
    logic w_unused_mid;
    assign w_unused_mid = ^{r_vld[0], r_op[0], r_sgn[0], r_sat[0], r_amsb[0], r_bmsb[0],
                            r_c[0], r_a[0], r_b[0], r_sum[0]};
  end

  // Intermediate pipeline registers: operands, partial sum and slice carry
  always_ff @(posedge clk or negedge rst_n) begin : p_pipe
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k]  <= 1'b0;
        r_op[k]   <= 1'b0;
        r_sgn[k]  <= 1'b0;
        r_sat[k]  <= 1'b0;
        r_amsb[k] <= 1'b0;
        r_bmsb[k] <= 1'b0;
        r_c[k]    <= 1'b0;
        r_a[k]    <= '0;
        r_b[k]    <= '0;
        r_sum[k]  <= '0;
      end
    end else if (w_en) begin
      for (int k = 0; k < int'(LAST); k++) begin
        r_vld[k]  <= w_s_vld[k];
        r_op[k]   <= w_s_op[k];
        r_sgn[k]  <= w_s_sgn[k];
        r_sat[k]  <= w_s_sat[k];
        r_amsb[k] <= w_s_amsb[k];
        r_bmsb[k] <= w_s_bmsb[k];
        r_c[k]    <= w_sl_cout[k];
        r_a[k]    <= w_s_a[k];
        r_b[k]    <= w_s_b[k];
        r_sum[k]  <= w_o_sum[k];
      end
    end
  end

  logic             w_c;
  logic             w_carry;
  logic             w_sovf;
  logic             w_ovf;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_final;

  // Final-stage flags; carry/ovf always describe the raw result
  assign w_c     = w_sl_cout[LAST];
  assign w_res   = w_o_sum[LAST];
  assign w_carry = (w_s_op[LAST] == OP_SUB) ? ~w_c : w_c;
  assign w_sovf  = (w_s_op[LAST] == OP_ADD)
                 ? ((w_s_amsb[LAST] == w_s_bmsb[LAST]) && (w_res[WIDTH-1] != w_s_amsb[LAST]))
                 : ((w_s_amsb[LAST] != w_s_bmsb[LAST]) && (w_res[WIDTH-1] != w_s_amsb[LAST]));
  assign w_ovf   = w_s_sgn[LAST] ? w_sovf : w_carry;
  assign w_final = (w_s_sat[LAST] && w_ovf)
                 ? WIDTH'(sat_value(w_s_sgn[LAST], w_s_op[LAST], w_s_amsb[LAST], WIDTH))
                 : w_res;

  always_ff @(posedge clk or negedge rst_n) begin : p_out
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_carry  <= 1'b0;
      r_out_ovf    <= 1'b0;
    end else if (w_en) begin
      r_out_valid  <= w_s_vld[LAST];
      r_out_result <= w_final;
      r_out_carry  <= w_carry;
      r_out_ovf    <= w_ovf;
    end
  end

  // Set has priority over clear
  always_ff @(posedge clk or negedge rst_n) begin : p_sticky
    if (!rst_n) begin
      r_ovf_sticky <= 1'b0;
    end else if (r_out_valid && out_ready && r_out_ovf) begin
      r_ovf_sticky <= 1'b1;
    end else if (sticky_clr) begin
      r_ovf_sticky <= 1'b0;
    end
  end

  assign in_ready   = w_en;
  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_carry  = r_out_carry;
  assign out_ovf    = r_out_ovf;
  assign ovf_sticky = r_ovf_sticky;

endmodule
